// File: rtl/vga_cube_pkg.sv
// Shared types and the fixed cube edge table
// for the vga_cube frame sequencer.
package vga_cube_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEL,
      S_ISSUE,
      S_WAIT,
      S_POINT,
      S_NEXT,
      S_DONE
   } sched_state_t;

   localparam int CUBE_N_VERT = 8;
   localparam int CUBE_N_EDGE = 12;
   localparam int VIDX_W      = $clog2(CUBE_N_VERT);

   // Front face, back face, then the four connecting edges.
   localparam logic [VIDX_W-1:0] CUBE_EDGES [CUBE_N_EDGE][2] = '{
      '{3'd0, 3'd1}, '{3'd1, 3'd2}, '{3'd2, 3'd3}, '{3'd3, 3'd0},
      '{3'd4, 3'd5}, '{3'd5, 3'd6}, '{3'd6, 3'd7}, '{3'd7, 3'd4},
      '{3'd0, 3'd4}, '{3'd1, 3'd5}, '{3'd2, 3'd6}, '{3'd3, 3'd7}
   };

endpackage

// File: rtl/cube_edge_sched.sv
// Frame sequencer: walks the cube edge table, feeds the
// shared line drawer and forwards its pixels to the writer.
module cube_edge_sched
   import vga_cube_pkg::*;
#(
   parameter int XY_BITW = 16,
   parameter int N_VERT  = 8,
   parameter int N_EDGE  = 12,
   parameter int TMO_W   = 18
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_start,
   input  logic [N_VERT*XY_BITW-1:0] vert_x,
   input  logic [N_VERT*XY_BITW-1:0] vert_y,
   input  logic [N_EDGE-1:0]         edge_en,
   output logic                      ln_start,
   output logic                      ln_oe,
   output logic [XY_BITW-1:0]        ln_x0,
   output logic [XY_BITW-1:0]        ln_y0,
   output logic [XY_BITW-1:0]        ln_x1,
   output logic [XY_BITW-1:0]        ln_y1,
   input  logic [XY_BITW-1:0]        ln_x,
   input  logic [XY_BITW-1:0]        ln_y,
   input  logic                      ln_drawing,
   input  logic                      ln_done,
   output logic                      pix_valid,
   output logic [XY_BITW-1:0]        pix_x,
   output logic [XY_BITW-1:0]        pix_y,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      overrun,
   output logic                      timeout
);

   localparam int KW = $clog2(N_EDGE);

   sched_state_t              state_q, state_d;
   logic [KW-1:0]             k_q, k_d;
   logic [TMO_W-1:0]          wd_q, wd_d, wd_inc;
   logic [N_VERT*XY_BITW-1:0] vx_q, vy_q;
   logic [N_EDGE-1:0]         en_q;
   logic                      overrun_q, overrun_d;
   logic                      timeout_q, timeout_d;
   logic                      oe_q;

   logic [VIDX_W-1:0]         va, vb;
   logic [XY_BITW-1:0]        xa, ya, xb, yb;
   logic                      edge_on, ep_eq;

   assign va      = CUBE_EDGES[k_q][0];
   assign vb      = CUBE_EDGES[k_q][1];
   assign xa      = vx_q[int'(va)*XY_BITW +: XY_BITW];
   assign ya      = vy_q[int'(va)*XY_BITW +: XY_BITW];
   assign xb      = vx_q[int'(vb)*XY_BITW +: XY_BITW];
   assign yb      = vy_q[int'(vb)*XY_BITW +: XY_BITW];
   assign edge_on = en_q[k_q];
   assign ep_eq   = (xa == xb) && (ya == yb);
   assign wd_inc  = wd_q + TMO_W'(1);

   assign busy    = (state_q != S_IDLE);
   assign ln_oe   = oe_q;
   assign overrun = overrun_q;
   assign timeout = timeout_q;

   // State, edge index, watchdog, sticky flags and the frame snapshot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         wd_q      <= '0;
         vx_q      <= '0;
         vy_q      <= '0;
         en_q      <= '0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         wd_q      <= wd_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         oe_q      <= 1'b1;
         if (state_q == S_LOAD) begin
            vx_q <= vert_x;
            vy_q <= vert_y;
            en_q <= edge_en;
         end
      end
   end

   // Edge walk: next state, drawer handshake and pixel forwarding.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      wd_d       = wd_q;
      overrun_d  = overrun_q;
      timeout_d  = timeout_q;
      ln_start   = 1'b0;
      ln_x0      = '0;
      ln_y0      = '0;
      ln_x1      = '0;
      ln_y1      = '0;
      pix_valid  = 1'b0;
      pix_x      = '0;
      pix_y      = '0;
      frame_done = 1'b0;

      if (frame_start && (state_q != S_IDLE))
         overrun_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (frame_start)
               state_d = S_LOAD;
         end
         S_LOAD: begin
            k_d     = '0;
            state_d = S_SEL;
         end
         S_SEL: begin
            if (!edge_on) begin
               state_d = S_NEXT;
            end else begin
               ln_x0   = xa;
               ln_y0   = ya;
               ln_x1   = xb;
               ln_y1   = yb;
               state_d = ep_eq ? S_POINT : S_ISSUE;
            end
         end
         S_ISSUE: begin
            ln_start = 1'b1;
            ln_x0    = xa;
            ln_y0    = ya;
            ln_x1    = xb;
            ln_y1    = yb;
            wd_d     = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            ln_x0     = xa;
            ln_y0     = ya;
            ln_x1     = xb;
            ln_y1     = yb;
            pix_valid = ln_drawing | ln_done;
            pix_x     = pix_valid ? ln_x : '0;
            pix_y     = pix_valid ? ln_y : '0;
            wd_d      = wd_inc;
            if (ln_done) begin
               state_d = S_NEXT;
            end else if (&wd_inc) begin
               timeout_d = 1'b1;
               state_d   = S_NEXT;
            end
         end
         S_POINT: begin
            pix_valid = 1'b1;
            pix_x     = xa;
            pix_y     = ya;
            state_d   = S_NEXT;
         end
         S_NEXT: begin
            if (k_q == KW'(N_EDGE - 1)) begin
               state_d = S_DONE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = S_SEL;
            end
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cube_edge_sched.sv
// Bench for cube_edge_sched with a behavioural Bresenham
// drawer (or a never-finishing stub) on the drawer side.
module tb_cube_edge_sched;

   localparam int XW = 16;
   localparam int TW = 4;

   typedef struct packed {
      int x;
      int y;
      int err;
   } bst_t;

   typedef struct packed {
      logic [127:0] vx;
      logic [127:0] vy;
      logic [11:0]  en;
      int           n_st;
      int           n_pix;
      int           tail;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic [127:0]  vert_x = '0;
   logic [127:0]  vert_y = '0;
   logic [11:0]   edge_en = '0;
   logic          ln_start, ln_oe;
   logic [XW-1:0] ln_x0, ln_y0, ln_x1, ln_y1;
   logic [XW-1:0] ln_x, ln_y;
   logic          ln_drawing, ln_done;
   logic          pix_valid;
   logic [XW-1:0] pix_x, pix_y;
   logic          busy, frame_done, overrun, timeout;

   always #5 clk = ~clk;

   cube_edge_sched #(
      .XY_BITW(XW), .N_VERT(8), .N_EDGE(12), .TMO_W(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .vert_x(vert_x), .vert_y(vert_y), .edge_en(edge_en),
      .ln_start(ln_start), .ln_oe(ln_oe),
      .ln_x0(ln_x0), .ln_y0(ln_y0), .ln_x1(ln_x1), .ln_y1(ln_y1),
      .ln_x(ln_x), .ln_y(ln_y),
      .ln_drawing(ln_drawing), .ln_done(ln_done),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .busy(busy), .frame_done(frame_done),
      .overrun(overrun), .timeout(timeout)
   );

   int EA[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
   int EB[12] = '{1, 2, 3, 0, 5, 6, 7, 4, 4, 5, 6, 7};

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int isgn(input int v);
      return (v < 0) ? -1 : 1;
   endfunction

   function automatic bst_t bstep(input bst_t s, input int dx,
                                  input int dy, input int sx,
                                  input int sy);
      bst_t n;
      int   e2;
      n  = s;
      e2 = 2 * s.err;
      if (e2 >= dy) begin
         n.err = n.err + dy;
         n.x   = n.x + sx;
      end
      if (e2 <= dx) begin
         n.err = n.err + dx;
         n.y   = n.y + sy;
      end
      return n;
   endfunction

   function automatic logic [127:0] pack8(input int a0, a1, a2, a3,
                                          input int a4, a5, a6, a7);
      logic [127:0] r;
      r[  0 +: 16] = 16'(a0);
      r[ 16 +: 16] = 16'(a1);
      r[ 32 +: 16] = 16'(a2);
      r[ 48 +: 16] = 16'(a3);
      r[ 64 +: 16] = 16'(a4);
      r[ 80 +: 16] = 16'(a5);
      r[ 96 +: 16] = 16'(a6);
      r[112 +: 16] = 16'(a7);
      return r;
   endfunction

   // ---------------- behavioural drawer ----------------
   logic stub = 1'b0;
   logic dr_act = 1'b0;
   bst_t cur;
   int   ex, ey, ddx, ddy, sx, sy;
   logic at_end;

   assign at_end = (cur.x == ex) && (cur.y == ey);

   always @(posedge clk) begin
      if (!rst_n) begin
         dr_act <= 1'b0;
      end else if (ln_start) begin
         dr_act <= 1'b1;
         cur    <= '{x: int'(ln_x0), y: int'(ln_y0),
                     err: iabs(int'(ln_x1) - int'(ln_x0))
                        - iabs(int'(ln_y1) - int'(ln_y0))};
         ex     <= int'(ln_x1);
         ey     <= int'(ln_y1);
         ddx    <= iabs(int'(ln_x1) - int'(ln_x0));
         ddy    <= -iabs(int'(ln_y1) - int'(ln_y0));
         sx     <= isgn(int'(ln_x1) - int'(ln_x0));
         sy     <= isgn(int'(ln_y1) - int'(ln_y0));
      end else if (dr_act) begin
         if (at_end) dr_act <= 1'b0;
         else        cur    <= bstep(cur, ddx, ddy, sx, sy);
      end
   end

   assign ln_x       = stub ? 16'd99 : (dr_act ? cur.x[15:0] : 16'd0);
   assign ln_y       = stub ? 16'd99 : (dr_act ? cur.y[15:0] : 16'd0);
   assign ln_drawing = stub ? 1'b1 : dr_act;
   assign ln_done    = stub ? 1'b0 : (dr_act && at_end);

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic [31:0] got_pix[$];
   logic [63:0] got_st[$];
   int          ndone_tot = 0;
   int          zviol_tot = 0;
   int          done_cyc = 0;
   int          last_ldone = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pix_valid)
         got_pix.push_back({pix_x, pix_y});
      else if ((pix_x != 0) || (pix_y != 0))
         zviol_tot <= zviol_tot + 1;
      if (ln_start)
         got_st.push_back({ln_x0, ln_y0, ln_x1, ln_y1});
      if (frame_done) begin
         ndone_tot <= ndone_tot + 1;
         done_cyc  <= cyc;
      end
      if (ln_done && !stub)
         last_ldone <= cyc;
   end

   // ---------------- model and checking ----------------
   logic [31:0] exp_pix[$];
   logic [63:0] exp_st[$];
   int          exp_cost;
   int          nvec = 0;
   int          nfail = 0;
   int          b_pix, b_st, b_done, b_z, c0;

   task automatic check(input string nm, input longint got,
                        input longint exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected start endpoints, pixel stream and cycle cost of one frame.
   task automatic model_frame(input logic [127:0] vx,
                              input logic [127:0] vy,
                              input logic [11:0]  en);
      exp_pix.delete();
      exp_st.delete();
      exp_cost = 0;
      for (int e = 0; e < 12; e++) begin
         int   x0, y0, x1, y1, n;
         bst_t s;
         x0 = int'(vx[EA[e]*16 +: 16]);
         y0 = int'(vy[EA[e]*16 +: 16]);
         x1 = int'(vx[EB[e]*16 +: 16]);
         y1 = int'(vy[EB[e]*16 +: 16]);
         if (!en[e]) begin
            exp_cost += 2;
         end else if ((x0 == x1) && (y0 == y1)) begin
            exp_pix.push_back({16'(x0), 16'(y0)});
            exp_cost += 3;
         end else begin
            exp_st.push_back({16'(x0), 16'(y0), 16'(x1), 16'(y1)});
            s = '{x: x0, y: y0, err: iabs(x1 - x0) - iabs(y1 - y0)};
            n = 0;
            while (1) begin
               exp_pix.push_back({16'(s.x), 16'(s.y)});
               n++;
               if (((s.x == x1) && (s.y == y1)) || (n > 4000)) break;
               s = bstep(s, iabs(x1 - x0), -iabs(y1 - y0),
                         isgn(x1 - x0), isgn(y1 - y0));
            end
            exp_cost += n + 3;
         end
      end
   endtask

   task automatic start_frame();
      b_pix  = got_pix.size();
      b_st   = got_st.size();
      b_done = ndone_tot;
      b_z    = zviol_tot;
      frame_start = 1'b1;
      c0 = cyc;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((ndone_tot == b_done) && (n < budget)) begin
         tick();
         n++;
      end
      repeat (3) tick();
   endtask

   task automatic compare_frame(input string tag);
      int bad, np, ns;
      np = got_pix.size() - b_pix;
      ns = got_st.size() - b_st;
      check({tag, ".npix"}, np, exp_pix.size());
      bad = 0;
      for (int i = 0; i < np && i < exp_pix.size(); i++)
         if (got_pix[b_pix + i] !== exp_pix[i]) bad++;
      check({tag, ".pixdata"}, bad, 0);
      check({tag, ".nstart"}, ns, exp_st.size());
      bad = 0;
      for (int i = 0; i < ns && i < exp_st.size(); i++)
         if (got_st[b_st + i] !== exp_st[i]) bad++;
      check({tag, ".startdata"}, bad, 0);
      check({tag, ".ndone"}, ndone_tot - b_done, 1);
      check({tag, ".cycles"}, done_cyc - c0, 2 + exp_cost);
      check({tag, ".pixzero"}, zviol_tot - b_z, 0);
      check({tag, ".idle"}, busy, 0);
   endtask

   vec_t         tbl[3];
   logic [127:0] sqx, sqy;

   initial begin
      sqx = pack8(10, 20, 20, 10, 15, 25, 25, 15);
      sqy = pack8(10, 10, 20, 20, 15, 15, 25, 25);
      tbl[0] = '{sqx, sqy, 12'hFFF, 12, 112, 2};
      tbl[1] = '{sqx, sqy, 12'h00F, 4, 44, 18};
      tbl[2] = '{pack8(7, 7, 20, 10, 15, 25, 25, 15),
                 pack8(7, 7, 20, 20, 15, 15, 25, 25),
                 12'h001, 0, 1, -1};

      // reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("reset.flags",
            {busy, ln_start, ln_oe, pix_valid, frame_done,
             overrun, timeout}, 0);
      check("reset.coords",
            |{pix_x, pix_y, ln_x0, ln_y0, ln_x1, ln_y1}, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      check("reset.oe", ln_oe, 1);

      // table-driven frames
      for (int i = 0; i < 3; i++) begin
         vert_x  = tbl[i].vx;
         vert_y  = tbl[i].vy;
         edge_en = tbl[i].en;
         model_frame(tbl[i].vx, tbl[i].vy, tbl[i].en);
         start_frame();
         wait_done(2000);
         compare_frame($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d.tstarts", i),
               got_st.size() - b_st, tbl[i].n_st);
         check($sformatf("tbl%0d.tpix", i),
               got_pix.size() - b_pix, tbl[i].n_pix);
         if (tbl[i].tail >= 0)
            check($sformatf("tbl%0d.tail", i),
                  done_cyc - last_ldone, tbl[i].tail);
      end
      check("tbl.no_overrun", overrun, 0);

      // second frame_start 3 cycles in
      vert_x  = sqx;
      vert_y  = sqy;
      edge_en = 12'hFFF;
      model_frame(sqx, sqy, 12'hFFF);
      start_frame();
      repeat (2) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      wait_done(2000);
      compare_frame("ovr");
      check("ovr.flag", overrun, 1);

      // inputs changed mid-frame must not matter
      model_frame(sqx, sqy, 12'hFFF);
      start_frame();
      repeat (5) tick();
      vert_x  = pack8(60, 70, 70, 60, 65, 75, 75, 65);
      edge_en = 12'h000;
      wait_done(2000);
      compare_frame("snap");
      vert_x  = sqx;
      edge_en = 12'hFFF;

      // reset while the drawer is running
      start_frame();
      begin
         int n;
         n = 0;
         while (!(busy && ln_drawing && pix_valid) && (n < 100)) begin
            tick();
            n++;
         end
         check("rst.reached_wait", n < 100, 1);
      end
      rst_n = 1'b0;
      tick();
      check("rst.flags",
            {busy, ln_start, ln_oe, pix_valid, frame_done,
             overrun, timeout}, 0);
      check("rst.coords",
            |{pix_x, pix_y, ln_x0, ln_y0, ln_x1, ln_y1}, 0);
      rst_n = 1'b1;
      repeat (4) tick();
      check("rst.nodone", ndone_tot - b_done, 0);
      check("rst.idle", busy, 0);

      // random frames, edges kept shorter than the watchdog
      for (int r = 0; r < 20; r++) begin
         vert_x = pack8(100 + $urandom_range(0, 12), 100 + $urandom_range(0, 12),
                        100 + $urandom_range(0, 12), 100 + $urandom_range(0, 12),
                        100 + $urandom_range(0, 12), 100 + $urandom_range(0, 12),
                        100 + $urandom_range(0, 12), 100 + $urandom_range(0, 12));
         vert_y = pack8(200 + $urandom_range(0, 12), 200 + $urandom_range(0, 12),
                        200 + $urandom_range(0, 12), 200 + $urandom_range(0, 12),
                        200 + $urandom_range(0, 12), 200 + $urandom_range(0, 12),
                        200 + $urandom_range(0, 12), 200 + $urandom_range(0, 12));
         edge_en = 12'($urandom);
         model_frame(vert_x, vert_y, edge_en);
         start_frame();
         wait_done(2000);
         compare_frame($sformatf("rnd%0d", r));
      end
      check("rnd.no_timeout", timeout, 0);

      // drawer never finishes: watchdog ends the edge
      stub    = 1'b1;
      vert_x  = sqx;
      vert_y  = sqy;
      edge_en = 12'h001;
      start_frame();
      wait_done(500);
      check("tmo.flag", timeout, 1);
      check("tmo.ndone", ndone_tot - b_done, 1);
      check("tmo.npix", got_pix.size() - b_pix, 15);
      check("tmo.nstart", got_st.size() - b_st, 1);
      check("tmo.cycles", done_cyc - c0, 2 + 18 + 22);
      stub = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
